gate_mem_responder: RTL and testbench

GATE_MEM_RESPONDER -- requirements
Module: gate_mem_responder

---
 rtl/gate_tester_pkg.sv | 33 +++
 rtl/gate_mem.sv | 51 +++++
 rtl/gate_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_gate_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Package  : gate_tester_pkg
// | Purpose  : Command codes, responder state encoding and DUT address map
// |            shared by the gate tester blocks. RESP_CHECKSUM_EN adds the
// |            checksum states.
// | Revision : 1.0
// +----------------------------------------------------------------------------
package gate_tester_pkg;

   localparam logic [7:0]  CMD_READ     = 8'h01;
   localparam logic [7:0]  CMD_WRITE    = 8'h02;

   localparam logic [15:0] DUT_OUT_ADDR = 16'h0000;
   localparam logic [15:0] DUT_IN_ADDR  = 16'h0008;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      RD_FETCH  = 4'd1,
      RD_SEND   = 4'd2,
      RD_WAIT   = 4'd3,
      RD_GAP    = 4'd4,
      WR_WAIT   = 4'd5,
      WR_STORE  = 4'd6,
`ifdef RESP_CHECKSUM_EN
      CSUM_SEND = 4'd7,
      CSUM_WAIT = 4'd8,
`endif
      FINISH    = 4'd9
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gate_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : gate_mem
// | Purpose  : MEM_DEPTH x 8 single-port RAM, synchronous write, registered read.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module gate_mem #(
   parameter int MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  wdata_i,
   output logic [7:0]  rdata_o
);
   localparam int ADDR_W = $clog2(MEM_DEPTH);

   logic [7:0]        mem_q [MEM_DEPTH];
   logic [7:0]        rdata_q;
   logic [ADDR_W-1:0] w_idx;

   assign w_idx = addr_i[ADDR_W-1:0];

   // Upper address bits are range-checked by the caller before any access.
   generate
      if (ADDR_W < 16) begin : g_addr_trim
         logic w_unused_addr;
         assign w_unused_addr = ^addr_i[15:ADDR_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[w_idx] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= 8'h00;
      end else if (re_i) begin
         rdata_q <= mem_q[w_idx];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/gate_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : gate_mem_responder
// | Purpose  : Serves read/write range commands against gate_mem over a
// |            byte handshake. Define RESP_CHECKSUM_EN to append an XOR
// |            checksum byte to every read.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module gate_mem_responder
   import gate_tester_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int TX_GAP    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  command,
   input  logic [15:0] start_address,
   input  logic [15:0] end_address,
   output logic        cmd_ready,
   input  logic        rx_done,
   input  logic [7:0]  rx_byte,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   input  logic        tx_done,
   output logic        done,
   output logic        err
);
   localparam logic [16:0] DEPTH_EXT = 17'(MEM_DEPTH);
   localparam logic [15:0] GAP_LAST  = (TX_GAP > 0) ? 16'(TX_GAP - 1) : 16'd0;
`ifdef RESP_CHECKSUM_EN
   localparam state_t      RD_EXIT   = CSUM_SEND;
`else
   localparam state_t      RD_EXIT   = FINISH;
`endif

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] end_q, end_d;
   logic [15:0] gap_q, gap_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        err_q, err_d;

   logic        w_mem_we, w_mem_re, w_last, w_cmd_ok, w_rd_advance;
   logic [7:0]  w_mem_rdata;

   gate_mem #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (w_mem_we),
      .re_i    (w_mem_re),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (w_mem_rdata)
   );

   assign w_last   = (addr_q == end_q);
   assign w_cmd_ok = ((command == CMD_READ) || (command == CMD_WRITE))
                     && (start_address <= end_address)
                     && ({1'b0, end_address} < DEPTH_EXT);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      end_d        = end_q;
      gap_d        = gap_q;
      csum_d       = csum_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      w_mem_we     = 1'b0;
      w_mem_re     = 1'b0;
      w_rd_advance = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (w_cmd_ok) begin
                  err_d   = 1'b0;
                  addr_d  = start_address;
                  end_d   = end_address;
                  csum_d  = 8'h00;
                  state_d = (command == CMD_READ) ? RD_FETCH : WR_WAIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end
            end
         end
         RD_FETCH: begin
            w_mem_re = 1'b1;
            state_d  = RD_SEND;
         end
         RD_SEND: begin
            csum_d  = csum_q ^ w_mem_rdata;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (tx_done) begin
               gap_d = 16'd0;
               if (TX_GAP > 0) begin
                  state_d = RD_GAP;
               end else begin
                  w_rd_advance = 1'b1;
               end
            end
         end
         RD_GAP: begin
            if (gap_q == GAP_LAST) begin
               w_rd_advance = 1'b1;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         WR_WAIT: begin
            if (rx_done) begin
               wdata_d = rx_byte;
               state_d = WR_STORE;
            end
         end
         WR_STORE: begin
            w_mem_we = 1'b1;
            if (w_last) begin
               state_d = FINISH;
            end else begin
               addr_d  = addr_q + 16'd1;
               state_d = WR_WAIT;
            end
         end
`ifdef RESP_CHECKSUM_EN
         CSUM_SEND: state_d = CSUM_WAIT;
         CSUM_WAIT: begin
            if (tx_done) begin
               state_d = FINISH;
            end
         end
`endif
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Termination compares against end_q so a range ending at 16'hFFFF never wraps.
      if (w_rd_advance) begin
         if (w_last) begin
            state_d = RD_EXIT;
         end else begin
            addr_d  = addr_q + 16'd1;
            state_d = RD_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 16'd0;
         end_q   <= 16'd0;
         gap_q   <= 16'd0;
         csum_q  <= 8'h00;
         wdata_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         gap_q   <= gap_d;
         csum_q  <= csum_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign done      = (state_q == FINISH);
   assign err       = err_q;

   // The read register holds the byte until the next fetch, keeping tx_byte stable.
`ifdef RESP_CHECKSUM_EN
   assign tx_start = (state_q == RD_SEND) || (state_q == CSUM_SEND);
   assign tx_byte  = ((state_q == CSUM_SEND) || (state_q == CSUM_WAIT)) ? csum_q : w_mem_rdata;
`else
   assign tx_start = (state_q == RD_SEND);
   assign tx_byte  = w_mem_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_mem_responder.sv
`default_nettype none
// Self-checking bench for gate_mem_responder: random read/write ranges against
// a byte-array model, handshake timing, error rejection and mid-transfer reset.
`timescale 1ns/1ps
module tb_gate_mem_responder;
   import gate_tester_pkg::*;

   localparam int MEM_DEPTH = 256;
   localparam int TX_GAP    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  command = 8'h00;
   logic [15:0] start_address = 16'd0;
   logic [15:0] end_address = 16'd0;
   logic        cmd_ready;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_done = 1'b0;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   gate_mem_responder #(
      .MEM_DEPTH (MEM_DEPTH),
      .TX_GAP    (TX_GAP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .command       (command),
      .start_address (start_address),
      .end_address   (end_address),
      .cmd_ready     (cmd_ready),
      .rx_done       (rx_done),
      .rx_byte       (rx_byte),
      .tx_start      (tx_start),
      .tx_byte       (tx_byte),
      .tx_done       (tx_done),
      .done          (done),
      .err           (err)
   );

   typedef struct { logic [7:0] b; bit csum; } txe_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [7:0]  mem_m [MEM_DEPTH];
   txe_t        exp_q [$];
   logic [7:0]  got_q [$];
   logic [7:0]  wr_q [$];
   int          tx_total = 0;
   int          tx_seen = 0;
   int          done_cnt = 0;
   int          last_done_cyc = 0;
   int          stall_at = -1;
   bit          in_flight = 1'b0;
   bit          first_tx = 1'b1;
   bit          rx_noise = 1'b0;
   logic [7:0]  held = 8'h00;
   txe_t        cur_e;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Compare process: every tx_start must match the next modelled byte.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         in_flight = 1'b0;
         first_tx  = 1'b1;
      end else begin
         if (done) done_cnt++;
         if (in_flight) check_eq("tx_byte_hold", {24'd0, tx_byte}, {24'd0, held});
         if (in_flight && tx_done) begin
            in_flight     = 1'b0;
            last_done_cyc = cyc;
         end
         if (tx_start) begin
            tx_total++;
            if (in_flight) check_eq("tx_start_overlap", {31'd0, tx_start}, 32'd0);
            if (exp_q.size() == 0) begin
               check_eq("tx_start_unexpected", {31'd0, tx_start}, 32'd0);
            end else begin
               cur_e = exp_q.pop_front();
               check_eq(cur_e.csum ? "tx_csum" : "tx_data", {24'd0, tx_byte}, {24'd0, cur_e.b});
               if (!first_tx && !cur_e.csum)
                  check_eq("tx_gap", cyc - last_done_cyc, TX_GAP + 2);
            end
            first_tx  = 1'b0;
            in_flight = 1'b1;
            held      = tx_byte;
            got_q.push_back(tx_byte);
         end
      end
   end

   // Transmitter model: answers each tx_start with tx_done after 1..4 cycles.
   initial forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
         tx_seen++;
         if (tx_seen != stall_at) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 if (!rst) tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   // Stray rx_done pulses while reads are running.
   initial forever begin
      @(posedge clk);
      #1;
      if (rx_noise && ($urandom_range(0, 3) == 0)) begin
         rx_byte = 8'($urandom);
         rx_done = 1'b1;
         @(posedge clk);
         #1 rx_done = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs();
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
   endtask

   task automatic issue(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e, input bit ok);
      int t = 0;
      while (!cmd_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      command = c; start_address = s; end_address = e; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check_eq("cmd_ready_drop", {31'd0, cmd_ready}, 32'd0);
      check_eq("err_on_accept", {31'd0, err}, {31'd0, !ok});
   endtask

   task automatic finish_cmd(input int base, input bit exp_err);
      int t = 0;
      while (done_cnt == base && t < 3000) begin
         @(posedge clk); #2; t++;
      end
      check_eq("done_count", done_cnt - base, 32'd1);
      check_eq("done_pulse_width", {31'd0, done}, 32'd0);
      check_eq("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
      check_eq("err_after_done", {31'd0, err}, {31'd0, exp_err});
      check_eq("tx_missing", exp_q.size(), 32'd0);
      #1;
   endtask

   task automatic write_cmd(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e, input bit poke);
      bit ok = ((c == CMD_READ) || (c == CMD_WRITE)) && (s <= e) && (e < MEM_DEPTH);
      int base = done_cnt;
      logic [7:0] b;
      issue(c, s, e, ok);
      if (ok && c == CMD_WRITE) begin
         for (int a = s; a <= int'(e); a++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            if (poke && a == int'(s)) begin
               command = CMD_READ; start_address = 16'd0; end_address = 16'd0; cmd_valid = 1'b1;
               check_eq("busy_ready", {31'd0, cmd_ready}, 32'd0);
               @(posedge clk);
               #1 cmd_valid = 1'b0;
            end
            b = (wr_q.size() != 0) ? wr_q.pop_front() : 8'($urandom);
            rx_byte = b; rx_done = 1'b1;
            @(posedge clk);
            #1 rx_done = 1'b0;
            mem_m[a] = b;
         end
      end
      finish_cmd(base, !ok);
   endtask

   task automatic read_cmd(input logic [15:0] s, input logic [15:0] e, input bit poke);
      bit ok = (s <= e) && (e < MEM_DEPTH);
      int base = done_cnt;
      logic [7:0] cs = 8'h00;
      if (ok) begin
         for (int a = s; a <= int'(e); a++) begin
            exp_q.push_back('{b: mem_m[a], csum: 1'b0});
            cs ^= mem_m[a];
         end
`ifdef RESP_CHECKSUM_EN
         exp_q.push_back('{b: cs, csum: 1'b1});
`endif
      end
      first_tx = 1'b1;
      rx_noise = 1'b1;
      issue(CMD_READ, s, e, ok);
      fork
         finish_cmd(base, !ok);
         if (poke) begin
            repeat (3) @(posedge clk);
            #1 command = CMD_WRITE; start_address = 16'd0; end_address = 16'd0; cmd_valid = 1'b1;
            check_eq("busy_ready", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
         end
      join
      rx_noise = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int tb0;
      int t;
      logic [15:0] s, e, rs, re;

      repeat (3) @(posedge clk);
      #1 check_reset_outputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single-byte write then read back at the DUT input region.
      wr_q = '{8'hB4};
      write_cmd(CMD_WRITE, DUT_IN_ADDR, DUT_IN_ADDR, 1'b0);
      idx = got_q.size();
      read_cmd(DUT_IN_ADDR, DUT_IN_ADDR, 1'b0);
      check_eq("lit_b4", {24'd0, (got_q.size() > idx) ? got_q[idx] : 8'hxx}, 32'hB4);

      // Four-byte write/read at the output region.
      wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      write_cmd(CMD_WRITE, DUT_OUT_ADDR, 16'd3, 1'b1);
      idx = got_q.size();
      read_cmd(DUT_OUT_ADDR, 16'd3, 1'b1);
      check_eq("lit_byte0", {24'd0, (got_q.size() > idx)     ? got_q[idx]     : 8'hxx}, 32'h11);
      check_eq("lit_byte3", {24'd0, (got_q.size() > idx + 3) ? got_q[idx + 3] : 8'hxx}, 32'h44);
`ifdef RESP_CHECKSUM_EN
      check_eq("lit_csum", {24'd0, (got_q.size() > idx + 4) ? got_q[idx + 4] : 8'hxx}, 32'h44);
`endif

      // Rejected commands: no tx_start, err sticky until the next valid command.
      tb0 = tx_total;
      read_cmd(16'd5, 16'd2, 1'b0);
      write_cmd(CMD_WRITE, 16'd0, 16'd256, 1'b0);
      write_cmd(CMD_WRITE, 16'd0, 16'hFFFF, 1'b0);
      write_cmd(8'h03, 16'd0, 16'd3, 1'b0);
      write_cmd(8'h00, 16'd8, 16'd8, 1'b0);
      check_eq("err_no_tx", tx_total - tb0, 32'd0);
      repeat (4) @(posedge clk);
      #1 check_eq("err_sticky", {31'd0, err}, 32'd1);
      read_cmd(16'd0, 16'd3, 1'b0);
      read_cmd(16'd8, 16'd8, 1'b0);

      // Reset while waiting for tx_done of the second byte.
      stall_at = tx_seen + 2;
      for (int a = 0; a < 4; a++) exp_q.push_back('{b: mem_m[a], csum: 1'b0});
      first_tx = 1'b1;
      tb0 = tx_total;
      issue(CMD_READ, 16'd0, 16'd3, 1'b1);
      t = 0;
      while (tx_total < tb0 + 2 && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check_eq("stall_reached", tx_total - tb0, 32'd2);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset_outputs();
      @(posedge clk);
      #1 rst = 1'b0;
      tb0 = done_cnt;
      repeat (40) @(posedge clk);
      #1 check_eq("no_tx_after_rst", tx_total - (tb0 - tb0) - tx_total + (tx_seen - stall_at), 32'd0);
      check_eq("no_done_after_rst", done_cnt - tb0, 32'd0);
      check_eq("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
      stall_at = -1;

      // Random ranges, plus the top-of-memory boundary; memory is rewritten after reset.
      write_cmd(CMD_WRITE, 16'd248, 16'd255, 1'b0);
      read_cmd(16'd255, 16'd255, 1'b0);
      read_cmd(16'd248, 16'd255, 1'b1);
      for (int i = 0; i < 20; i++) begin
         s = 16'($urandom_range(0, MEM_DEPTH - 1));
         e = 16'($urandom_range(0, 7)) + s;
         if (e > 16'(MEM_DEPTH - 1)) e = 16'(MEM_DEPTH - 1);
         write_cmd(CMD_WRITE, s, e, i[0]);
         rs = 16'($urandom_range(int'(s), int'(e)));
         re = 16'($urandom_range(int'(rs), int'(e)));
         read_cmd(rs, re, i[1]);
      end
      read_cmd(16'd248, 16'd255, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
